// File: rtl/mem_stall_ctrl.sv
// Data-memory stall controller: holds the pipeline while a load/store waits on dmem_ready, abandons it on kill/timeout.
// dmem_req/stall/wb_bubble are combinational from state and inputs; bus_err and stall_cycles are registered one cycle later.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic        kill,
  input  logic        dmem_ready,
  input  logic        perf_clr,
  output logic        dmem_req,
  output logic        stall,
  output logic        wb_bubble,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        acc;
  logic        in_wait;
  logic        timeout_hit;

  assign acc = MemRead_mem | MemWrite_mem;
  // Reset forces the output decode to IDLE regardless of the registered state.
  assign in_wait     = (state == WAIT) && !reset;
  assign timeout_hit = in_wait && !kill && !dmem_ready && (wait_cnt == TIMEOUT_W);

  always_comb begin
    dmem_req  = 1'b0;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    if (in_wait) begin
      dmem_req  = !kill && !timeout_hit;
      stall     = !kill && !dmem_ready && !timeout_hit;
      wb_bubble = kill || !dmem_ready;
    end else begin
      dmem_req  = acc && !kill;
      stall     = acc && !kill && !dmem_ready && !reset;
      wb_bubble = kill || (acc && !dmem_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 16'd0;
      bus_err      <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      bus_err <= timeout_hit;

      if (perf_clr)
        stall_cycles <= 32'd0;
      else if (stall)
        stall_cycles <= stall_cycles + 32'd1;

      case (state)
        IDLE: begin
          if (acc && !kill && !dmem_ready) begin
            state    <= WAIT;
            wait_cnt <= 16'd1;
          end
        end
        WAIT: begin
          // acc is ignored here: the stalled EX/MEM keeps presenting the same access.
          if (kill || dmem_ready || timeout_hit)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt + 16'd1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before an access is abandoned; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 MemRead_mem  input  1  load in MEM stage (EX/MEM output).
REQ-005 MemWrite_mem  input  1  store in MEM stage (EX/MEM output).
REQ-006 kill  input  1  exception/redirect; cancels any in-flight access.
REQ-007 dmem_ready  input  1  data memory completes the presented access this cycle.
REQ-008 perf_clr  input  1  clears stall_cycles.
REQ-009 dmem_req  output  1  access request to data memory (combinational).
REQ-010 stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM (combinational).
REQ-011 wb_bubble  output  1  forces RegWrite_in and MemtoReg_in of MEM/WB to 0 (combinational).
REQ-012 bus_err  output  1  registered one-cycle pulse on timeout.
REQ-013 stall_cycles  output  32  registered count of cycles with stall=1.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-015 acc SHALL be defined as MemRead_mem | MemWrite_mem.
REQ-016 dmem_req SHALL be (IDLE & acc & ~kill) | (WAIT & ~kill & ~timeout_hit).
REQ-017 IDLE, acc=0 or kill=1: stall=0, wb_bubble=kill, the FSM SHALL stay in IDLE.
REQ-018 IDLE, acc=1, dmem_ready=1, kill=0: zero-wait access; stall=0, wb_bubble=0, the FSM SHALL stay in IDLE.
REQ-019 IDLE, acc=1, dmem_ready=0, kill=0: stall=1, wb_bubble=1, wait counter loaded with 1, the FSM SHALL go to WAIT.
REQ-020 WAIT, dmem_ready=1, kill=0: stall=0, wb_bubble=0 (MEM/WB captures the real result), the FSM SHALL go to IDLE.
REQ-021 WAIT, dmem_ready=0, wait counter < TIMEOUT, kill=0: stall=1, wb_bubble=1, the wait counter SHALL increment and the FSM SHALL stay in WAIT.
REQ-022 WAIT, dmem_ready=0, wait counter == TIMEOUT (timeout_hit): dmem_req=0, stall=0, wb_bubble=1, bus_err=1 on the next cycle, the FSM SHALL go to IDLE.
REQ-023 WAIT, kill=1: takes priority over dmem_ready and timeout; dmem_req=0, stall=0, wb_bubble=1, no bus_err, the FSM SHALL go to IDLE.
REQ-024 The wait counter SHALL be 16 bits wide and SHALL never wrap; its value is don't-care in IDLE.
REQ-025 While in WAIT, the controller relies on MemRead_mem/MemWrite_mem being held by the stalled EX/MEM; a drop of acc in WAIT SHALL NOT change the FSM behaviour.
REQ-026 stall_cycles SHALL increment by 1 on every cycle with stall=1, wrapping 0xFFFFFFFF -> 0.
REQ-027 perf_clr=1 SHALL load stall_cycles with 0 and take priority over the increment in the same cycle.
REQ-028 Back-to-back accesses: an access completing in WAIT followed by a new acc in the next cycle SHALL be handled from IDLE per REQ-018/019 with no idle gap.

Reset
REQ-029 With reset=1 at posedge clk, the FSM SHALL enter IDLE and the wait counter, bus_err and stall_cycles SHALL clear to 0.
REQ-030 Reset SHALL take priority over kill, perf_clr and dmem_ready.
REQ-031 While reset=1, the combinational outputs SHALL decode from IDLE (dmem_req follows REQ-016, stall=0).
REQ-032 Reset during WAIT SHALL abandon the access with no bus_err pulse.

Verification
REQ-033 Load with dmem_ready=1 in the same cycle -> stall and wb_bubble never asserted; stall_cycles stays 0.
REQ-034 Store, dmem_ready rises on the 4th cycle -> stall=1 for 3 cycles, wb_bubble=1 for 3 cycles, dmem_req=1 for 4 cycles, stall_cycles=3.
REQ-035 TIMEOUT=4, dmem_ready held at 0 -> stall=1 for 4 cycles, then one cycle with dmem_req=0, stall=0, wb_bubble=1; bus_err pulses exactly once on the following cycle.
REQ-036 kill asserted in the 2nd WAIT cycle while dmem_ready=1 -> dmem_req=0, wb_bubble=1, no bus_err, FSM in IDLE next cycle.
REQ-037 reset asserted mid-WAIT, then a new load with immediate dmem_ready -> FSM in IDLE, stall_cycles=0, the load completes with zero wait.
REQ-038 stall_cycles preset to 0xFFFFFFFF with a stall cycle -> wraps to 0; perf_clr together with stall -> 0.
